// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
package demux_pkg;
    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;
    localparam int CW_DEF  = 8;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_slot.sv
// One single-entry output slot: data register, valid flop and a
// delivered-word counter driven by the slot's own valid/ready handshake.
module demux_slot #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  d,
    input  logic          ready,
    output logic [W-1:0]  o,
    output logic          valid,
    output logic [CW-1:0] cnt
);
    logic [W-1:0]  data_q;
    logic          valid_q;
    logic [CW-1:0] cnt_q;
    logic          take;

    // ready while empty is ignored
    assign take = valid_q & ready;

    // Load wins over take, so a same-cycle take+load keeps the slot full
    // with the new word; the counter tracks takes independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (load) begin
                data_q  <= d;
                valid_q <= 1'b1;
            end else if (take) begin
                valid_q <= 1'b0;
            end
            if (take) cnt_q <= cnt_q + CW'(1);
        end
    end

    assign o     = data_q;
    assign valid = valid_q;
    assign cnt   = cnt_q;
endmodule

// File: rtl/demux_4s_buf.sv
// Registered 1-to-4 demux: steers one valid/ready input word per cycle
// into one of four single-entry slots, each with its own valid/ready port.
module demux_4s_buf
    import demux_pkg::*;
#(
    parameter int w  = 4,
    parameter int CW = CW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [w-1:0]       d,
    input  sel_t               sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [w-1:0]       o0,
    output logic [w-1:0]       o1,
    output logic [w-1:0]       o2,
    output logic [w-1:0]       o3,
    output logic [NUM_OUT-1:0] o_valid,
    input  logic [NUM_OUT-1:0] o_ready,
    output logic [CW-1:0]      cnt0,
    output logic [CW-1:0]      cnt1,
    output logic [CW-1:0]      cnt2,
    output logic [CW-1:0]      cnt3
);
    logic [NUM_OUT-1:0][w-1:0]  slot_o;
    logic [NUM_OUT-1:0][CW-1:0] slot_cnt;
    logic [NUM_OUT-1:0]         load;
    logic                       acc;

    // Only the selected slot gates acceptance; a slot being drained this
    // cycle can take a new word in the same cycle.
    assign in_ready = ~o_valid[sel] | o_ready[sel];
    assign acc      = in_valid & in_ready;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        assign load[k] = acc & (sel == sel_t'(k));

        demux_slot #(.W(w), .CW(CW)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .d     (d),
            .ready (o_ready[k]),
            .o     (slot_o[k]),
            .valid (o_valid[k]),
            .cnt   (slot_cnt[k])
        );
    end

    assign o0   = slot_o[0];
    assign o1   = slot_o[1];
    assign o2   = slot_o[2];
    assign o3   = slot_o[3];
    assign cnt0 = slot_cnt[0];
    assign cnt1 = slot_cnt[1];
    assign cnt2 = slot_cnt[2];
    assign cnt3 = slot_cnt[3];
endmodule

// File: doc/demux_4s_buf.md
# demux_4s_buf

Registered 1-to-4 demultiplexer: the write-side counterpart of the team's 4:1 select mux. It accepts one `w`-bit word per cycle on a valid/ready input and steers it by `sel` into one of four single-entry output slots. Each slot presents the word downstream on its own valid/ready port and keeps an 8-bit delivered-word count. It sits between a shared producer and four independent consumers.

## Interface
Parameters:
- `w`, 4, data width in bits (≥1)
- `CW`, 8, width of each per-output delivered-word counter

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `d`  in  w  input data word
- `sel`  in  2  destination slot index, 0..3; sampled with `d`
- `in_valid`  in  1  producer offers `d`/`sel`
- `in_ready`  out  1  block accepts the word this cycle
- `o0`,`o1`,`o2`,`o3`  out  w each  slot data, registered
- `o_valid`  out  4  bit k: slot k holds a word
- `o_ready`  in  4  bit k: consumer k takes the word this cycle
- `cnt0`..`cnt3`  out  CW each  words delivered from slot k, modulo 2^CW

## Operation
- Input accept: `acc = in_valid & in_ready`.
- `in_ready = ~o_valid[sel] | o_ready[sel]`. This is combinational from `sel`, slot state and `o_ready`, with no dependence on `in_valid`. The states of unselected slots do not affect it.
- Output take: `take[k] = o_valid[k] & o_ready[k]`. `o_ready[k]` while `o_valid[k]`=0 has no effect.
- Slot k next state, with `load[k] = acc & (sel==k)`:
  - load[k]: `o_k <= d`, `o_valid[k] <= 1`. Covers simultaneous take and load on the same slot: the new word replaces the old one and valid stays 1.
  - take[k] & ~load[k]: `o_valid[k] <= 0`. `o_k` holds its last value.
  - otherwise hold.
- Counter: `cnt_k <= cnt_k + 1` on take[k]. It wraps from 2^CW−1 to 0 with no saturation or flag.
- Up to one load per cycle, and up to four takes in the same cycle, all independent.
- `o_k` is don't-care while `o_valid[k]`=0. Benches must not check it then.
- No reordering within a slot. Words for different slots may be delivered in any order relative to each other.
- Producer rule: while `in_valid`=1 and `in_ready`=0, the producer holds `d` and `sel` stable. The block does not check this.

## Timing
- Reset (async assert, sync deassert handled upstream): `o_valid`=4'b0000, `o0..o3`=0, `cnt0..cnt3`=0. `in_ready` then reads 1 for any `sel`.
- Reset mid-operation: any buffered words are discarded with no delivery, and counters clear.
- Latency: a word accepted at edge N gives `o_valid[sel]`=1 with the data on `o_k` after edge N, visible in cycle N+1.
- Throughput: one word per cycle to a single slot when its consumer holds `o_ready`=1. It also sustains one word per cycle round-robin across slots.
- Back-pressure: if slot k is full and `o_ready[k]`=0, a word for k stalls. A simultaneous offer to a different, empty slot is not possible because only one `sel` is presented per cycle.
- No combinational path from `d` to any output. The paths `sel`/`o_ready` → `in_ready` are combinational.

## Structure
- Package `demux_pkg`:
  - `localparam NUM_OUT = 4`
  - `localparam SEL_W = 2`
  - `localparam CW_DEF = 8`
  - slot index typedef `sel_t` (logic [SEL_W-1:0])
- Sub-module `demux_slot`, instantiated 4×. It contains one data register, a valid flop and a CW-bit counter. Ports: `clk`, `rst_n`, `load`, `d`, `ready`, `o`, `valid`, `cnt`.
- Top level holds the `in_ready` mux and the `load` decode only.

## Test plan
- Reset, then idle: `o_valid`=0000, all `cnt`=0, `in_ready`=1 for each `sel` 0..3.
- Fan-out with all `o_ready`=1, w=4: send d=4'hA/sel=0, 4'h5/sel=1, 4'h3/sel=2, 4'hC/sel=3 on consecutive cycles. Each `o_k` shows its word one cycle after accept, each `cnt_k`=1, and `in_ready` stays 1 throughout.
- Back-pressure: `o_ready`=0000, send 4'h1 to sel=2 and then 4'h2 to sel=2. The second word sees `in_ready`=0 and `o2`=4'h1. Raise `o_ready[2]` for one cycle: 4'h2 is accepted that same cycle, `o2`=4'h2 next cycle, `cnt2`=1.
- Full-slot isolation: slot 0 full and stalled, offer 4'h7 to sel=3. It is accepted immediately and `o_valid`=1001.
- Counter wrap: CW=8, stream 256 words to sel=1 with `o_ready[1]`=1. `cnt1` returns to 0 and `cnt0`, `cnt2`, `cnt3` remain 0.
- Async reset mid-stream: assert `rst_n`=0 between edges while `o_valid`=1111. All outputs clear immediately without waiting for `clk`, and the first post-reset word is delivered normally with `cnt`=1.
